// File: rtl/image_stream_reader.sv
// Image stream reader: fetches LEN words from data memory starting at
// BASE_ADDR and streams byte [7:0] of each word over valid/ready.
module image_stream_reader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned LEN_W     = 17
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             ABORT,
  output logic [31:0]      MEM_ADDR,
  output logic             MEM_RE,
  input  logic [31:0]      RD,
  output logic [7:0]       PIX_DATA,
  output logic             PIX_VALID,
  input  logic             PIX_READY,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             infl_q, infl_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [7:0]       fifo_q [2];

  logic       issue;
  logic       push;
  logic       pop;
  logic       clr;
  logic       more;
  logic       pix_valid;
  logic [2:0] credit;
  logic       rd_hi_unused;

  assign rd_hi_unused = ^RD[31:8];

  assign pix_valid = (cnt_q != 2'd0);
  assign pop       = pix_valid && PIX_READY;
  assign more      = (idx_q < len_q);
  assign credit    = {1'b0, cnt_q} + {2'b00, infl_q};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    issue   = 1'b0;
    push    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          if (LEN != '0) begin
            // First read goes out in the accept cycle to keep latency at 2.
            len_d   = LEN;
            issue   = 1'b1;
            idx_d   = idx_q + LEN_W'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FETCH: begin
        if (ABORT) begin
          clr     = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          push  = infl_q;
          issue = more && (credit < ({2'b00, pop} + 3'd2));
          if (issue) begin
            idx_d = idx_q + LEN_W'(1);
          end
          if (!more && !infl_q &&
              ((cnt_q == 2'd0) ||
               ((cnt_q == 2'd1) && pop))) begin
            idx_d   = '0;
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    infl_d   = issue;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    if (clr) begin
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      infl_q   <= 1'b0;
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      infl_q   <= infl_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= 8'h00;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= RD[7:0];
    end
  end

  assign MEM_RE    = issue;
  assign MEM_ADDR  = issue ? (BASE_ADDR + 32'(idx_q)) : 32'd0;
  assign PIX_DATA  = fifo_q[rd_ptr_q];
  assign PIX_VALID = pix_valid;
  assign BUSY      = (state_q == S_FETCH);
  assign DONE      = (state_q == S_FINISH);

endmodule

// File: tb/tb_image_stream_reader.sv
// Directed bench for image_stream_reader with a memory model
// and a pixel scoreboard queue.
module tb_image_stream_reader;

  localparam logic [31:0] BASE = 32'd100;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [16:0] LEN;
  logic        ABORT;
  logic [31:0] MEM_ADDR;
  logic        MEM_RE;
  logic [31:0] RD;
  logic [7:0]  PIX_DATA;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic        BUSY;
  logic        DONE;

  image_stream_reader #(
    .BASE_ADDR(BASE),
    .LEN_W(17)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .LEN(LEN),
    .ABORT(ABORT),
    .MEM_ADDR(MEM_ADDR),
    .MEM_RE(MEM_RE),
    .RD(RD),
    .PIX_DATA(PIX_DATA),
    .PIX_VALID(PIX_VALID),
    .PIX_READY(PIX_READY),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  logic [31:0] mem [256];
  logic [7:0]  exp_q [$];

  int checks;
  int errors;
  int re_cnt;
  int done_cnt;
  int issued;
  int popped;
  logic [31:0] exp_addr;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    RD <= MEM_RE ? mem[MEM_ADDR[7:0]] : $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_xfer(input logic [16:0] len);
    logic [31:0] w;
    START    = 1'b1;
    LEN      = len;
    exp_addr = BASE;
    for (int i = 0; i < int'(len); i++) begin
      w = mem[(int'(BASE) + i) % 256];
      exp_q.push_back(w[7:0]);
    end
  endtask

  initial begin
    int d0;
    int r0;
    int n;
    logic [3:0] pat;
    checks    = 0;
    errors    = 0;
    re_cnt    = 0;
    done_cnt  = 0;
    issued    = 0;
    popped    = 0;
    exp_addr  = BASE;
    RST       = 1'b1;
    START     = 1'b0;
    LEN       = '0;
    ABORT     = 1'b0;
    PIX_READY = 1'b1;
    pat       = 4'b1001;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {$urandom} ^ 32'(i);
    end
    mem[100] = 32'h0000_0011;
    mem[101] = 32'h0000_0022;
    mem[102] = 32'h0000_0033;
    mem[103] = 32'h0000_0044;

    fork
      begin : monitor
        logic prev_stall;
        logic prev_abort;
        logic [7:0] prev_data;
        logic pop;
        logic [7:0] e;
        int oc;
        prev_stall = 1'b0;
        prev_abort = 1'b0;
        prev_data  = 8'h00;
        forever begin
          @(negedge CLK);
          if (RST) begin
            prev_stall = 1'b0;
          end else begin
            pop = PIX_VALID && PIX_READY;
            if (prev_stall && !prev_abort) begin
              chk("hold_valid", PIX_VALID, 1);
              chk("hold_data", PIX_DATA, prev_data);
            end
            if (MEM_RE) begin
              chk("mem_addr", MEM_ADDR, exp_addr);
              exp_addr++;
              re_cnt++;
              issued++;
              oc = issued - popped - (pop ? 1 : 0);
              chk("credit", oc <= 2, 1);
            end
            if (pop) begin
              chk("sb_nonempty", exp_q.size() != 0, 1);
              if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pix_data", PIX_DATA, e);
              end
              popped++;
            end
            if (DONE) done_cnt++;
            prev_stall = PIX_VALID && !PIX_READY;
            prev_data  = PIX_DATA;
            prev_abort = ABORT;
          end
        end
      end
    join_none

    @(negedge CLK);
    chk("rst_re", MEM_RE, 0);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_valid", PIX_VALID, 0);
    chk("rst_data", PIX_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    step();
    #2 RST = 1'b0;

    // basic stream
    step();
    r0 = re_cnt;
    start_xfer(4);
    @(negedge CLK);
    chk("t1_re0", MEM_RE, 1);
    chk("t1_busy0", BUSY, 0);
    step();
    START = 1'b0;
    @(negedge CLK);
    chk("t1_v1", PIX_VALID, 0);
    chk("t1_busy1", BUSY, 1);
    for (int c = 2; c <= 5; c++) begin
      @(negedge CLK);
      chk("t1_valid", PIX_VALID, 1);
      if (c == 2) chk("t1_first", PIX_DATA, 32'h11);
    end
    @(negedge CLK);
    chk("t1_done", DONE, 1);
    chk("t1_v6", PIX_VALID, 0);
    chk("t1_busy6", BUSY, 0);
    @(negedge CLK);
    chk("t1_done7", DONE, 0);
    chk("t1_sb", exp_q.size(), 0);
    chk("t1_reads", re_cnt - r0, 4);

    // backpressure
    step();
    d0 = done_cnt;
    r0 = re_cnt;
    start_xfer(6);
    step();
    START = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 80) begin
      PIX_READY = pat[n % 4];
      @(negedge CLK);
      step();
      n++;
    end
    PIX_READY = 1'b1;
    chk("t2_timeout", n < 80, 1);
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_reads", re_cnt - r0, 6);
    chk("t2_sb", exp_q.size(), 0);

    // zero length
    step();
    r0 = re_cnt;
    start_xfer(0);
    @(negedge CLK);
    chk("t3_re", MEM_RE, 0);
    chk("t3_done0", DONE, 0);
    step();
    START = 1'b0;
    @(negedge CLK);
    chk("t3_done1", DONE, 1);
    chk("t3_valid", PIX_VALID, 0);
    chk("t3_busy", BUSY, 0);
    @(negedge CLK);
    chk("t3_done2", DONE, 0);
    chk("t3_reads", re_cnt - r0, 0);

    // abort mid-stream
    step();
    d0 = done_cnt;
    start_xfer(10);
    step();
    START = 1'b0;
    repeat (4) step();
    PIX_READY = 1'b0;
    chk("t4_sb3", exp_q.size(), 7);
    step();
    step();
    ABORT = 1'b1;
    @(negedge CLK);
    chk("t4_stall_v", PIX_VALID, 1);
    step();
    ABORT = 1'b0;
    @(negedge CLK);
    chk("t4_valid", PIX_VALID, 0);
    chk("t4_busy", BUSY, 0);
    exp_q.delete();
    issued = 0;
    popped = 0;
    r0 = re_cnt;
    repeat (3) @(negedge CLK);
    chk("t4_noreads", re_cnt - r0, 0);
    chk("t4_nodone", done_cnt - d0, 0);
    PIX_READY = 1'b1;
    step();
    d0 = done_cnt;
    r0 = re_cnt;
    start_xfer(2);
    step();
    START = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("t4_redone", done_cnt - d0, 1);
    chk("t4_rereads", re_cnt - r0, 2);
    chk("t4_sb", exp_q.size(), 0);

    // async reset mid-transfer
    step();
    start_xfer(8);
    step();
    START = 1'b0;
    step();
    step();
    #3 RST = 1'b1;
    #1;
    chk("t5_re", MEM_RE, 0);
    chk("t5_addr", MEM_ADDR, 0);
    chk("t5_valid", PIX_VALID, 0);
    chk("t5_data", PIX_DATA, 0);
    chk("t5_busy", BUSY, 0);
    chk("t5_done", DONE, 0);
    exp_q.delete();
    issued = 0;
    popped = 0;
    step();
    step();
    #2 RST = 1'b0;
    r0 = re_cnt;
    repeat (4) begin
      @(negedge CLK);
      chk("t5_idle_v", PIX_VALID, 0);
      chk("t5_idle_b", BUSY, 0);
    end
    chk("t5_noreads", re_cnt - r0, 0);

    // upper bits ignored, START during BUSY ignored
    mem[100] = 32'hDEAD_BE5A;
    step();
    d0 = done_cnt;
    r0 = re_cnt;
    start_xfer(3);
    step();
    LEN = 17'd5;
    @(negedge CLK);
    chk("t6_busy", BUSY, 1);
    step();
    START = 1'b0;
    @(negedge CLK);
    chk("t6_data", PIX_DATA, 32'h5A);
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    repeat (4) @(negedge CLK);
    chk("t6_done", done_cnt - d0, 1);
    chk("t6_reads", re_cnt - r0, 3);
    chk("t6_sb", exp_q.size(), 0);
    chk("t6_idle", BUSY, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
